// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out frame receiver: assembles sof-delimited WIDTH-bit frames
// into a holding register with a valid/ready handshake and framing/overrun flags.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sof,
    input  logic             dout_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] shift_first;
    logic             complete;
    logic             ovr_set;

    always_comb begin
        if (MSB_FIRST) begin
            shift_next  = {shift_q[WIDTH-2:0], sin};
            shift_first = {{(WIDTH-1){1'b0}}, sin};
        end else begin
            shift_next  = {sin, shift_q[WIDTH-1:1]};
            shift_first = {sin, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        complete     = 1'b0;
        ovr_set      = 1'b0;

        case (state_q)
            IDLE: begin
                if (sin_en && sof) begin
                    shift_d = shift_first;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_en) begin
                    if (sof) begin
                        frame_err_d = 1'b1;
                        shift_d     = shift_first;
                        cnt_d       = CW'(1);
                    end else begin
                        shift_d = shift_next;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            complete = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing frame may load on the same edge the consumer accepts the old one.
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_next;
                dout_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        overrun_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
        busy_d    = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out frame receiver that pairs with the 4-bit PISO shift register: it is the receive end of the same serial link. It samples a qualified serial bit stream, assembles WIDTH-bit frames delimited by a start-of-frame marker, and presents each frame on a registered parallel output with a valid/ready handshake. A separate shift register and output holding register let the next frame be received while the consumer still holds the previous one. Framing and overrun errors are flagged.

## Interface
- WIDTH, default 4: bits per frame; legal range is WIDTH ≥ 2.
- MSB_FIRST, default 1: 1 means the first received bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].

- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset; asynchronous and active-low.
- sin  in  1  serial data bit.
- sin_en  in  1  bit strobe; sin is sampled only on edges where sin_en=1.
- sof  in  1  start-of-frame; meaningful only when sin_en=1; marks the current bit as bit 0 of a frame.
- dout_ready  in  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
- clr_ovr  in  1  synchronous clear of the sticky overrun flag.
- dout  out  WIDTH  received frame, held stable while dout_valid=1.
- dout_valid  out  1  dout holds an unaccepted frame.
- busy  out  1  a frame is partially received (FSM in SHIFT).
- frame_err  out  1  one-cycle pulse when a partial frame is aborted by a new sof.
- overrun  out  1  sticky; set when a completed frame is dropped.

## Operation
- Reset values: state=IDLE, shift register=0, bit counter=0, dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
- Bit counter width is clog2(WIDTH+1). The shift register is WIDTH bits wide.
  - MSB_FIRST=1: shift left, inserting sin at bit 0.
  - MSB_FIRST=0: shift right, inserting sin at bit WIDTH-1.
- FSM, two states:
  - IDLE: edges with sin_en=1 and sof=0 are ignored. On an edge with sin_en=1 and sof=1, capture sin as bit 0, set count=1, and go to SHIFT.
  - SHIFT: on sin_en=1 and sof=0, shift in sin and increment count.
    - When this edge captures bit WIDTH-1, the frame is complete. Go to IDLE and perform the completion rule below.
    - On sin_en=1 and sof=1 (resync), discard the partial frame, pulse frame_err, capture sin as the new bit 0, set count=1, and stay in SHIFT.
    - On sin_en=0, hold all state.
- Completion rule, evaluated on the edge that captures the last bit:
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 on the same edge: dout is loaded with the completed frame and dout_valid becomes 1.
  - Otherwise the new frame is dropped, overrun is set to 1, and dout is unchanged.
- Handshake: dout_valid falls on an edge with dout_valid=1, dout_ready=1 and no completion. dout never changes while dout_valid=1, except on an accept-and-load edge.
- overrun stays 1 until an edge with clr_ovr=1. If clr_ovr and a new overrun occur on the same edge, overrun remains 1.
- busy is 1 exactly while the state is SHIFT.
- Reset asserted mid-frame immediately returns all state to the reset values. The partial frame is lost and no error is flagged.

## Timing
- Sampling happens on the rising clk edge when sin_en=1. Gaps (sin_en=0) of any length are allowed within a frame.
- Latency: dout_valid and dout update on the same edge that samples the last bit, so they are visible right after that edge. With sin_en held at 1, dout_valid rises WIDTH edges after the sof edge, counting the sof edge as edge 1.
- The next frame's sof may arrive on the edge immediately after completion. Back-to-back frames need no idle cycle.
- frame_err is exactly one cycle wide and is registered.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset state: hold rst_n=0, then release → dout=0, dout_valid=0, busy=0, overrun=0.
- Basic frame: WIDTH=4, MSB_FIRST=1, dout_ready=0, sin_en=1, bits 1,0,1,1 with sof on the first bit → after the 4th edge dout=4'b1011 and dout_valid=1. Then pulse dout_ready=1 for one cycle → dout_valid=0.
- Bit order: MSB_FIRST=0 with the same bit stream → dout=4'b1101.
- Gaps and resync: send bits 1,0 with sin_en=0 for 3 cycles between them, then sof with bits 0,1,1,0 → frame_err pulses once and dout=4'b0110.
- Overrun and simultaneous events:
  - Receive 4'b1011 and hold dout_ready=0, then receive 4'b0001 → overrun=1, dout stays 4'b1011.
  - Pulse clr_ovr → overrun=0.
  - Receive 4'b1111 with dout_ready=1 on its last-bit edge → dout=4'b1111, dout_valid stays 1, overrun=0.
- Reset mid-frame: assert rst_n=0 after 2 bits → busy=0 immediately. A following full frame 4'b1001 is received correctly.
